// File: rtl/data_mem_bank.sv
// data_mem_bank: byte-addressed 32-bit data memory for the load/store path.
// Ports:
//   clk, rstn       clock and synchronous active-low reset
//   busy            high while the post-reset clear sweep runs
//   wr_en/wr_addr/wr_op/wr_data  store request (RV32 funct3 sb/sh/sw)
//   rd_en/rd_addr/rd_op          load request (lb/lh/lw/lbu/lhu)
//   rd_data/rd_valid             extended load result, one cycle later
//   misalign_err                 pulse for a rejected load or store
module data_mem_bank #(
    parameter int ADDR_W         = 17,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter     INIT_FILE      = ""
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [2:0]        wr_op,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_op,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              misalign_err
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t     state_q;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [1:0]  wr_off, rd_off;
    logic        wr_ok, rd_ok;
    logic [3:0]  be;
    logic [31:0] wdat;
    logic        idle, wr_fire, rd_fire, clr_we;
    logic [31:0] rd_word;

    logic        rvld_q, rbad_q, err_q;
    logic [31:0] rword_q, hold_q;
    logic [1:0]  roff_q;
    logic [2:0]  rop_q;
    logic [31:0] ext;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign wr_idx = wr_addr[ADDR_W-1:2];
    assign wr_off = wr_addr[1:0];
    assign rd_idx = rd_addr[ADDR_W-1:2];
    assign rd_off = rd_addr[1:0];
    assign cnt_d  = cnt_q + 1'b1;

    // Store lane steering: data is replicated so each enabled byte
    // lane already carries the right value.
    always_comb begin
        wr_ok = 1'b0;
        be    = 4'b0000;
        wdat  = wr_data;
        case (wr_op)
            3'd0: begin
                wr_ok = 1'b1;
                be    = 4'b0001 << wr_off;
                wdat  = {4{wr_data[7:0]}};
            end
            3'd1: begin
                wr_ok = ~wr_off[0];
                be    = wr_off[1] ? 4'b1100 : 4'b0011;
                wdat  = {2{wr_data[15:0]}};
            end
            3'd2: begin
                wr_ok = (wr_off == 2'd0);
                be    = 4'b1111;
            end
            default: wr_ok = 1'b0;
        endcase
    end

    always_comb begin
        rd_ok = 1'b0;
        case (rd_op)
            3'd0, 3'd4: rd_ok = 1'b1;
            3'd1, 3'd5: rd_ok = ~rd_off[0];
            3'd2:       rd_ok = (rd_off == 2'd0);
            default:    rd_ok = 1'b0;
        endcase
    end

    assign idle    = (state_q == S_IDLE);
    assign busy    = (state_q == S_CLEAR);
    assign clr_we  = busy & rstn;
    assign wr_fire = idle & rstn & wr_en & wr_ok;
    assign rd_fire = idle & rd_en;

    // Write-first bypass: a same-word store merges into the read word.
    always_comb begin
        rd_word = mem[rd_idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_fire && (wr_idx == rd_idx) && be[b])
                rd_word[8*b +: 8] = wdat[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt_q] <= 32'h0;
        end else if (wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[wr_idx][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == IDX_W'(DEPTH - 1))
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rvld_q  <= 1'b0;
            rbad_q  <= 1'b0;
            err_q   <= 1'b0;
            rword_q <= 32'h0;
            roff_q  <= 2'd0;
            rop_q   <= 3'd0;
            hold_q  <= 32'h0;
        end else begin
            rvld_q <= rd_fire;
            rbad_q <= rd_fire & ~rd_ok;
            err_q  <= idle & ((rd_en & ~rd_ok) | (wr_en & ~wr_ok));
            if (rd_fire) begin
                rword_q <= rd_word;
                roff_q  <= rd_off;
                rop_q   <= rd_op;
            end
            if (rvld_q)
                hold_q <= ext;
        end
    end

    assign lane_b = rword_q[{roff_q, 3'b000} +: 8];
    assign lane_h = roff_q[1] ? rword_q[31:16] : rword_q[15:0];

    always_comb begin
        ext = 32'h0;
        case (rop_q)
            3'd0:    ext = {{24{lane_b[7]}}, lane_b};
            3'd1:    ext = {{16{lane_h[15]}}, lane_h};
            3'd2:    ext = rword_q;
            3'd4:    ext = {24'h0, lane_b};
            3'd5:    ext = {16'h0, lane_h};
            default: ext = 32'h0;
        endcase
        if (rbad_q)
            ext = 32'h0;
    end

    // rd_data follows the fresh result on a valid cycle, else holds.
    assign rd_data      = rvld_q ? ext : hold_q;
    assign rd_valid     = rvld_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_data_mem_bank.sv
// tb_data_mem_bank: scoreboard bench for data_mem_bank (ADDR_W = 6).
// Stimulus pushes expected loads/errors; a negedge monitor checks them.
module tb_data_mem_bank;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rstn;
    logic          busy;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_op;
    logic [31:0]   wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [2:0]    rd_op;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic          misalign_err;

    int tests = 0;
    int fails = 0;
    logic [31:0] rdq[$];
    int err_pending = 0;

    data_mem_bank #(
        .ADDR_W(AW),
        .CLEAR_ON_RESET(1'b1),
        .INIT_FILE("")
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .busy(busy),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_op(wr_op),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_op(rd_op),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && rd_valid) begin
            tests++;
            if (rdq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rd_valid: got data %h expected none",
                         rd_data);
            end else begin
                logic [31:0] e;
                e = rdq.pop_front();
                if (rd_data !== e) begin
                    fails++;
                    $display("FAIL load_data: got %h expected %h", rd_data, e);
                end
            end
        end
        if (rstn && misalign_err) begin
            tests++;
            if (err_pending == 0) begin
                fails++;
                $display("FAIL unexpected_err: got 1 expected 0");
            end else begin
                err_pending--;
            end
        end
    end

    task automatic cyc(input logic we, input logic [AW-1:0] wa,
                       input logic [2:0] wo, input logic [31:0] wd,
                       input logic re, input logic [AW-1:0] ra,
                       input logic [2:0] ro);
        wr_en = we; wr_addr = wa; wr_op = wo; wr_data = wd;
        rd_en = re; rd_addr = ra; rd_op = ro;
        @(posedge clk); #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic ld(input logic [AW-1:0] a, input logic [2:0] op,
                      input logic [31:0] exp, input bit bad);
        rdq.push_back(exp);
        if (bad) err_pending++;
        cyc(1'b0, '0, 3'd0, 32'h0, 1'b1, a, op);
    endtask

    task automatic st(input logic [AW-1:0] a, input logic [2:0] op,
                      input logic [31:0] d, input bit bad);
        if (bad) err_pending++;
        cyc(1'b1, a, op, d, 1'b0, '0, 3'd0);
    endtask

    // Called right after rstn rises; hammers requests while busy.
    task automatic sweep(output int n);
        n = 0;
        wr_en = 1'b1; wr_addr = '0; wr_op = 3'd2; wr_data = 32'hDEADBEEF;
        rd_en = 1'b1; rd_addr = 6'h3; rd_op = 3'd3;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rstn = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_op = 3'd0; wr_data = 32'h0;
        rd_en = 1'b0; rd_addr = '0; rd_op = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("rst_err", {31'h0, misalign_err}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        rstn = 1'b1;
        sweep(n);
        chk("sweep_len", n, 16);

        for (int i = 0; i < 16; i++)
            ld(AW'(i * 4), 3'd2, 32'h0, 1'b0);

        st(6'h0, 3'd2, 32'h11223344, 1'b0);
        st(6'h1, 3'd0, 32'h000000AA, 1'b0);
        ld(6'h0, 3'd2, 32'h1122AA44, 1'b0);
        ld(6'h1, 3'd0, 32'hFFFFFFAA, 1'b0);
        ld(6'h1, 3'd4, 32'h000000AA, 1'b0);

        st(6'h6, 3'd1, 32'h00008001, 1'b0);
        ld(6'h6, 3'd1, 32'hFFFF8001, 1'b0);
        ld(6'h6, 3'd5, 32'h00008001, 1'b0);
        ld(6'h4, 3'd5, 32'h00000000, 1'b0);
        ld(6'h4, 3'd2, 32'h80010000, 1'b0);

        st(6'h2, 3'd2, 32'hFFFFFFFF, 1'b1);
        st(6'h0, 3'd3, 32'hFFFFFFFF, 1'b1);
        ld(6'h0, 3'd2, 32'h1122AA44, 1'b0);
        ld(6'h3, 3'd1, 32'h00000000, 1'b1);
        ld(6'h0, 3'd6, 32'h00000000, 1'b1);
        ld(6'h2, 3'd2, 32'h00000000, 1'b1);

        rdq.push_back(32'h00005A00);
        cyc(1'b1, 6'h9, 3'd0, 32'h0000005A, 1'b1, 6'h8, 3'd2);
        ld(6'h8, 3'd2, 32'h00005A00, 1'b0);
        rdq.push_back(32'h1122AA44);
        cyc(1'b1, 6'hC, 3'd2, 32'h12345678, 1'b1, 6'h0, 3'd2);
        ld(6'hC, 3'd2, 32'h12345678, 1'b0);

        st(6'h2, 3'd1, 32'h0000BEEF, 1'b0);
        ld(6'h0, 3'd2, 32'hBEEFAA44, 1'b0);
        ld(6'h2, 3'd1, 32'hFFFFBEEF, 1'b0);
        ld(6'h0, 3'd0, 32'h00000044, 1'b0);
        ld(6'h3, 3'd4, 32'h000000BE, 1'b0);
        ld(6'h3, 3'd0, 32'hFFFFFFBE, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rd_data_hold", rd_data, 32'hFFFFFFBE);
        @(posedge clk); #1;

        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        sweep(n);
        chk("sweep_restart_len", n, 16);
        ld(6'h0, 3'd2, 32'h0, 1'b0);
        ld(6'h8, 3'd2, 32'h0, 1'b0);
        ld(6'hC, 3'd2, 32'h0, 1'b0);
        ld(6'h3C, 3'd2, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("loads_outstanding", rdq.size(), 0);
        chk("errs_outstanding", err_pending, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
